// File: rtl/inst_mem_pipe.sv
// Instruction memory with a one-cycle registered fetch port and a streaming program-load FSM.
// Fetches decode misalignment and range faults and substitute NOP_WORD for anything not fetched from memory.
module inst_mem_pipe #(
  parameter int          DEPTH    = 64,
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_WORD = 32'h0000_0033
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [ADDR_W-1:0]        fetch_pc,
  input  logic                     fetch_stall,
  input  logic                     flush,
  output logic [31:0]              instr_out,
  output logic                     instr_valid,
  output logic                     fault_misalign,
  output logic                     fault_range,
  input  logic                     load_start,
  input  logic                     load_en,
  input  logic [31:0]              load_data,
  input  logic                     load_last,
  output logic                     load_busy,
  output logic                     load_done,
  output logic [$clog2(DEPTH):0]   load_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t        state, state_n;
  logic [AW-1:0] ptr, ptr_n;
  logic [AW:0]   cnt, cnt_n;
  logic          done_r, done_n;
  logic          mem_we;

  logic [31:0] mem [DEPTH];

  logic [ADDR_W-3:0] widx;
  logic              misalign, out_of_range, accept;

  logic [31:0] instr_p1;
  logic        vld_p1;
  logic        fmis_p1;
  logic        frng_p1;

  // Load FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      done_r <= done_n;
    end
  end

  // A restart takes precedence over a write in the same cycle; the last word ends the load without wrapping.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    done_n  = 1'b0;
    mem_we  = 1'b0;
    if (load_start) begin
      state_n = LOAD;
      ptr_n   = '0;
      cnt_n   = '0;
    end else if (state == LOAD && load_en) begin
      mem_we = 1'b1;
      ptr_n  = ptr + 1'b1;
      cnt_n  = cnt + 1'b1;
      if (load_last || ptr == AW'(DEPTH - 1)) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end
  end

  // Memory is never reset; a reset mid-load suppresses the write in that cycle.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[ptr] <= load_data;
  end

  assign widx         = fetch_pc[ADDR_W-1:2];
  assign misalign     = |fetch_pc[1:0];
  assign out_of_range = (32'(widx) >= 32'(DEPTH));
  assign accept       = fetch_req && (state == IDLE);

  // Stage p1: registered fetch result
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      instr_p1 <= NOP_WORD;
      vld_p1   <= 1'b0;
      fmis_p1  <= 1'b0;
      frng_p1  <= 1'b0;
    end else if (load_start) begin
      instr_p1 <= NOP_WORD;
      vld_p1   <= 1'b0;
    end else if (fetch_stall) begin
      instr_p1 <= instr_p1;
      vld_p1   <= vld_p1;
    end else if (accept) begin
      instr_p1 <= (misalign || out_of_range) ? NOP_WORD : mem[widx[AW-1:0]];
      vld_p1   <= 1'b1;
      fmis_p1  <= misalign;
      frng_p1  <= out_of_range;
    end else begin
      instr_p1 <= NOP_WORD;
      vld_p1   <= 1'b0;
    end
  end

  assign instr_out      = instr_p1;
  assign instr_valid    = vld_p1;
  assign fault_misalign = fmis_p1;
  assign fault_range    = frng_p1;
  assign load_busy      = (state == LOAD);
  assign load_done      = done_r;
  assign load_count     = cnt;

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Directed self-checking bench for inst_mem_pipe (DEPTH=64, ADDR_W=10).
module tb_inst_mem_pipe;

  localparam int          DEPTH  = 64;
  localparam int          ADDR_W = 10;
  localparam logic [31:0] NOP    = 32'h0000_0033;

  logic              clk = 1'b0;
  logic              rst, fetch_req, fetch_stall, flush;
  logic [ADDR_W-1:0] fetch_pc;
  logic [31:0]       instr_out;
  logic              instr_valid, fault_misalign, fault_range;
  logic              load_start, load_en, load_last, load_busy, load_done;
  logic [31:0]       load_data;
  logic [6:0]        load_count;

  int n_checks = 0;
  int n_errors = 0;

  inst_mem_pipe #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_stall(fetch_stall), .flush(flush),
    .instr_out(instr_out), .instr_valid(instr_valid),
    .fault_misalign(fault_misalign), .fault_range(fault_range),
    .load_start(load_start), .load_en(load_en), .load_data(load_data), .load_last(load_last),
    .load_busy(load_busy), .load_done(load_done), .load_count(load_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_en = 1'b1; load_data = d; load_last = last;
    tick();
    load_en = 1'b0; load_last = 1'b0;
  endtask

  task automatic fetch(input int pc);
    fetch_req = 1'b1; fetch_pc = ADDR_W'(pc);
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] w, input logic v);
    check_eq({tag, "_out"}, instr_out, w);
    check_eq({tag, "_vld"}, 32'(instr_valid), 32'(v));
  endtask

  initial begin
    rst = 1'b1; fetch_req = 0; fetch_pc = '0; fetch_stall = 0; flush = 0;
    load_start = 0; load_en = 0; load_data = '0; load_last = 0;
    tick(); tick();
    rst = 1'b0;
    check_out("rst", NOP, 1'b0);
    check_eq("rst_mis",   32'(fault_misalign), 32'd0);
    check_eq("rst_rng",   32'(fault_range),    32'd0);
    check_eq("rst_busy",  32'(load_busy),      32'd0);
    check_eq("rst_done",  32'(load_done),      32'd0);
    check_eq("rst_count", 32'(load_count),     32'd0);

    // Three-word program load
    load_start = 1'b1; tick(); load_start = 1'b0;
    check_eq("ld_busy", 32'(load_busy), 32'd1);
    load_word(32'h0000_0083, 1'b0);
    load_word(32'h0040_0103, 1'b0);
    load_word(32'h0020_8463, 1'b1);
    check_eq("ld_done",  32'(load_done),  32'd1);
    check_eq("ld_count", 32'(load_count), 32'd3);
    check_eq("ld_idle",  32'(load_busy),  32'd0);
    tick();
    check_eq("ld_done_once", 32'(load_done), 32'd0);
    fetch(0); check_out("f0", 32'h0000_0083, 1'b1);
    fetch(4); check_out("f4", 32'h0040_0103, 1'b1);
    fetch(8); check_out("f8", 32'h0020_8463, 1'b1);
    tick();   check_out("nofetch", NOP, 1'b0);

    // Stall hold then flush
    fetch_req = 1'b1; fetch_pc = 10'd4; tick();
    check_out("st0", 32'h0040_0103, 1'b1);
    fetch_stall = 1'b1; fetch_pc = 10'd8;
    for (int i = 0; i < 3; i++) begin
      tick(); check_out("stall", 32'h0040_0103, 1'b1);
    end
    fetch_stall = 1'b0; flush = 1'b1; tick();
    check_out("flush", NOP, 1'b0);
    flush = 1'b0; fetch_req = 1'b0;

    // Faults
    fetch(6);
    check_out("mis", NOP, 1'b1);
    check_eq("mis_m", 32'(fault_misalign), 32'd1);
    check_eq("mis_r", 32'(fault_range),    32'd0);
    fetch(256);
    check_out("rng", NOP, 1'b1);
    check_eq("rng_r", 32'(fault_range),    32'd1);
    check_eq("rng_m", 32'(fault_misalign), 32'd0);
    fetch(258);
    check_eq("both_m", 32'(fault_misalign), 32'd1);
    check_eq("both_r", 32'(fault_range),    32'd1);
    fetch(252);
    check_eq("edge_r", 32'(fault_range),    32'd0);
    fetch(0);
    check_out("clr", 32'h0000_0083, 1'b1);
    check_eq("clr_m", 32'(fault_misalign), 32'd0);
    check_eq("clr_r", 32'(fault_range),    32'd0);

    // Full 64-word load without load_last
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      load_word(32'hA000_0000 + 32'(i), 1'b0);
      if (i == DEPTH - 2) check_eq("full_busy62", 32'(load_busy), 32'd1);
    end
    check_eq("full_busy",  32'(load_busy),  32'd0);
    check_eq("full_done",  32'(load_done),  32'd1);
    check_eq("full_count", 32'(load_count), 32'd64);
    load_word(32'hDEAD_BEEF, 1'b0);
    check_eq("extra_count", 32'(load_count), 32'd64);
    check_eq("extra_done",  32'(load_done),  32'd0);
    fetch(0);   check_out("full_w0",  32'hA000_0000, 1'b1);
    fetch(252); check_out("full_w63", 32'hA000_003F, 1'b1);

    // Restart mid-load
    load_start = 1'b1; tick(); load_start = 1'b0;
    for (int i = 0; i < 5; i++) load_word(32'hB000_0000 + 32'(i), 1'b0);
    load_start = 1'b1; load_en = 1'b1; load_data = 32'hFFFF_FFFF; tick();
    load_start = 1'b0; load_en = 1'b0;
    check_eq("rs_count", 32'(load_count), 32'd0);
    check_eq("rs_busy",  32'(load_busy),  32'd1);
    check_eq("rs_done",  32'(load_done),  32'd0);
    load_word(32'hC000_0000, 1'b0);
    load_word(32'hC000_0001, 1'b1);
    check_eq("rs_count2", 32'(load_count), 32'd2);
    check_eq("rs_done2",  32'(load_done),  32'd1);
    fetch(0);  check_out("rs_w0", 32'hC000_0000, 1'b1);
    fetch(4);  check_out("rs_w1", 32'hC000_0001, 1'b1);
    fetch(8);  check_out("rs_w2", 32'hB000_0002, 1'b1);
    fetch(16); check_out("rs_w4", 32'hB000_0004, 1'b1);
    fetch(20); check_out("rs_w5", 32'hA000_0005, 1'b1);

    // Reset during load
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_word(32'hD000_0000, 1'b0);
    rst = 1'b1; load_en = 1'b1; load_data = 32'hD000_0001; tick();
    rst = 1'b0; load_en = 1'b0;
    check_eq("rl_busy",  32'(load_busy),  32'd0);
    check_eq("rl_count", 32'(load_count), 32'd0);
    check_eq("rl_done",  32'(load_done),  32'd0);
    check_out("rl", NOP, 1'b0);
    tick();
    check_eq("rl_nodone", 32'(load_done), 32'd0);
    fetch(0); check_out("rl_w0", 32'hD000_0000, 1'b1);
    fetch(4); check_out("rl_w1", 32'hC000_0001, 1'b1);

    // Reset during stall with a fault latched
    fetch_req = 1'b1; fetch_pc = 10'd6; tick();
    check_eq("rs_mis", 32'(fault_misalign), 32'd1);
    fetch_stall = 1'b1; tick();
    check_eq("rs_mis_hold", 32'(fault_misalign), 32'd1);
    check_out("rs_hold", NOP, 1'b1);
    rst = 1'b1; tick();
    rst = 1'b0; fetch_stall = 1'b0; fetch_req = 1'b0;
    check_out("rst_st", NOP, 1'b0);
    check_eq("rst_st_m", 32'(fault_misalign), 32'd0);
    check_eq("rst_st_r", 32'(fault_range),    32'd0);
    fetch(0); check_out("rst_st_w0", 32'hD000_0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_pipe.md
INST_MEM_PIPE -- requirements
Module: inst_mem_pipe

Interface
REQ-001 Parameter: DEPTH, 64, number of 32-bit instruction words; power of two, 4 to 4096.
REQ-002 Parameter: ADDR_W, 8, fetch byte-address width; SHALL be at least log2(DEPTH)+2.
REQ-003 Parameter: NOP_WORD, 32'h00000033, word substituted for invalid, flushed or reset output (add x0,x0,x0).
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst  in  1  synchronous active-high reset.
REQ-007 Port: fetch_req  in  1  fetch request for fetch_pc.
REQ-008 Port: fetch_pc  in  ADDR_W  byte address of the instruction.
REQ-009 Port: fetch_stall  in  1  hold the current output; the request is not accepted.
REQ-010 Port: flush  in  1  kill the output and any accepted request.
REQ-011 Port: instr_out  out  32  registered instruction word.
REQ-012 Port: instr_valid  out  1  instr_out is valid this cycle.
REQ-013 Port: fault_misalign  out  1  the presented word came from fetch_pc[1:0] != 0.
REQ-014 Port: fault_range  out  1  the presented word came from fetch_pc[ADDR_W-1:2] >= DEPTH.
REQ-015 Port: load_start  in  1  begin a program load at word 0.
REQ-016 Port: load_en  in  1  load_data is valid this cycle.
REQ-017 Port: load_data  in  32  instruction word to write.
REQ-018 Port: load_last  in  1  qualifies load_en; marks the final word of the load.
REQ-019 Port: load_busy  out  1  FSM is in LOAD.
REQ-020 Port: load_done  out  1  one-cycle pulse when a load ends.
REQ-021 Port: load_count  out  log2(DEPTH)+1  number of words written by the current or last load.

Function
REQ-022 The FSM SHALL have two states, IDLE and LOAD.
REQ-023 IDLE->LOAD: on load_start=1; write pointer := 0, load_count := 0.
REQ-024 LOAD: each load_en=1 writes load_data to mem[ptr], increments ptr and increments load_count.
REQ-025 LOAD->IDLE: on the write with load_last=1, or on the write to word DEPTH-1 (no wrap); load_done=1 in the following cycle only.
REQ-026 load_start while in LOAD SHALL restart the load: ptr := 0, load_count := 0, any load_en in that cycle ignored, no load_done.
REQ-027 load_en in IDLE SHALL be ignored; memory unchanged.
REQ-028 Fetch acceptance: fetch_req=1 & fetch_stall=0 & flush=0 & state=IDLE & load_start=0.
REQ-029 Fetch latency: exactly 1 cycle; on the next edge instr_out := mem[fetch_pc>>2] and instr_valid := 1.
REQ-030 Misaligned accepted fetch: instr_out := NOP_WORD, instr_valid := 1, fault_misalign := 1, memory not read.
REQ-031 Out-of-range accepted fetch: instr_out := NOP_WORD, instr_valid := 1, fault_range := 1.
REQ-032 Misaligned and out-of-range together: both faults SHALL be set.
REQ-033 Faults SHALL be registered alongside instr_out and cleared on the next accepted in-range, aligned fetch.
REQ-034 fetch_stall=1 & flush=0: instr_out, instr_valid and faults SHALL hold their values.
REQ-035 Priority: rst > flush > load_start > fetch_stall > fetch_req.
REQ-036 flush=1: next cycle instr_valid=0, instr_out=NOP_WORD, faults 0.
REQ-037 No accepted fetch and no stall (including any cycle in LOAD or with load_start=1): next cycle instr_valid=0 and instr_out=NOP_WORD.
REQ-038 Memory contents SHALL change only through the load port.

Reset
REQ-039 rst=1 at an edge: state=IDLE, instr_out=NOP_WORD, instr_valid=0, both faults 0, load_busy=0, load_done=0, load_count=0, ptr=0.
REQ-040 rst SHALL NOT clear memory contents; rst during LOAD SHALL abort the load without a load_done pulse, leaving already-written words intact.

Verification
REQ-041 Load 0x00000083, 0x00400103, 0x00208463 (load_last on the third) -> load_count=3, load_done pulses once; fetch pc 0,4,8 -> those words 1 cycle later, valid=1.
REQ-042 Fetch pc=4 with fetch_stall held 3 cycles -> instr_out=0x00400103 held, valid=1 throughout; flush -> valid=0, out=0x00000033.
REQ-043 With DEPTH=64: fetch pc=6 -> fault_misalign=1, out=NOP; fetch pc=256 with ADDR_W=10 -> fault_range=1, out=NOP; both faults 0 after fetch pc=0.
REQ-044 Stream 64 words without load_last -> auto return to IDLE after word 63, load_count=64; extra load_en ignored.
REQ-045 load_start mid-load after 5 words, then 2 words with load_last -> load_count=2, words 0-1 new, words 2-4 from the aborted load.
REQ-046 rst asserted during LOAD and during stall -> all outputs at reset values next cycle; memory retained, verified by fetch.
